// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding and defaults for the UART TX arbiter
package uart_tx_arbiter_pkg;
  localparam int TXARB_NUM_REQ = 3;
  localparam int TXARB_BUSY_TIMEOUT = 16;
  typedef enum logic [1:0] {
    TXARB_IDLE      = 2'd0,
    TXARB_LAUNCH    = 2'd1,
    TXARB_WAIT_BUSY = 2'd2,
    TXARB_WAIT_DONE = 2'd3
  } txarb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus transmitter handshake of the UART TX arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = uart_tx_arbiter_pkg::TXARB_NUM_REQ
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_rdy;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 err;
  modport master (
    output req_valid, req_data, req_last, tx_rdy,
    input  req_ready, tx_en, tx_data, grant_id, busy, err
  );
  modport slave (
    input  req_valid, req_data, req_last, tx_rdy,
    output req_ready, tx_en, tx_data, grant_id, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb_pick.sv
// rr_arb_pick: combinational round-robin picker, search starts one past last
module rr_arb_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic [2:0]   last_i,
  output logic [N-1:0] gnt_o,
  output logic [2:0]   idx_o,
  output logic         any_o
);
  logic [N-1:0]   cand;
  logic [2*N-1:0] dbl;
  logic [2:0]     start;
  logic [3:0]     pos;
  // Rotate the candidates so the preferred one sits at bit 0, then take the lowest set bit
  always_comb begin
    cand = req_i & mask_i;
    start = (last_i == 3'(N-1)) ? 3'd0 : last_i + 3'd1;
    dbl = {cand, cand} >> start;
    any_o = 1'b0;
    pos = '0;
    for (int k = N-1; k >= 0; k--)
      if (dbl[k]) begin
        any_o = 1'b1;
        pos = {1'b0, start} + 4'(k);
      end
    idx_o = 3'((pos >= 4'(N)) ? pos - 4'(N) : pos);
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter; burst lock via UART_TX_ARB_BURST_LOCK_EN
module uart_tx_arbiter import uart_tx_arbiter_pkg::*; #(
  parameter int NUM_REQ      = TXARB_NUM_REQ,
  parameter int BUSY_TIMEOUT = TXARB_BUSY_TIMEOUT
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  txarb_state_t        state_q, state_d;
  logic [7:0]          tx_data_q, tx_data_d, sel_data;
  logic [2:0]          grant_id_q, grant_id_d;
  logic [2:0]          last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  mask, gnt;
  logic [2:0]          pick;
  logic                any, grant, timeout;

  rr_arb_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (bus.req_valid),
    .mask_i (mask),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (pick),
    .any_o  (any)
  );

  // A grant is never issued while reset is held, so a reset cannot re-accept a byte
  assign grant = state_q == TXARB_IDLE && bus.tx_rdy && any && !rst;
  // A falling tx_rdy in the same cycle wins over the timeout
  assign timeout = state_q == TXARB_WAIT_BUSY && bus.tx_rdy && (cnt_q + CW'(1) == CW'(BUSY_TIMEOUT));

`ifdef UART_TX_ARB_BURST_LOCK_EN
  logic       lock_q, lock_d;
  logic [2:0] owner_q, owner_d;
  assign mask = lock_q ? NUM_REQ'(1) << owner_q : '1;
  // A non-final byte locks arbitration onto its sender; the final byte or a timeout unlocks
  always_comb begin
    lock_d = timeout ? 1'b0 : grant ? !(|(bus.req_last & gnt)) : lock_q;
    owner_d = grant ? pick : owner_q;
  end
  // Lock registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  assign mask = '1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= TXARB_IDLE;
    else state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      TXARB_IDLE:      state_d = grant ? TXARB_LAUNCH : TXARB_IDLE;
      TXARB_LAUNCH:    state_d = TXARB_WAIT_BUSY;
      TXARB_WAIT_BUSY: state_d = !bus.tx_rdy ? TXARB_WAIT_DONE : timeout ? TXARB_IDLE : TXARB_WAIT_BUSY;
      default:         state_d = bus.tx_rdy ? TXARB_IDLE : TXARB_WAIT_DONE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.req_ready = grant ? gnt : '0;
    bus.tx_en = state_q == TXARB_LAUNCH;
    bus.tx_data = tx_data_q;
    bus.grant_id = grant_id_q;
    bus.busy = state_q != TXARB_IDLE;
    bus.err = err_q | timeout;
  end

  // Datapath next values: byte capture on grant, busy-wait counter, sticky error
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) sel_data = bus.req_data[i*8 +: 8];
    tx_data_d = grant ? sel_data : tx_data_q;
    grant_id_d = grant ? pick : grant_id_q;
    last_d = grant ? pick : last_q;
    cnt_d = state_q == TXARB_LAUNCH ? '0 : state_q == TXARB_WAIT_BUSY ? cnt_q + CW'(1) : cnt_q;
    err_d = err_q | timeout;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= '0;
      grant_id_q <= '0;
      last_q <= 3'(NUM_REQ - 1);
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      grant_id_q <= grant_id_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed, table-driven check of the UART TX arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(3)) bus ();

  uart_tx_arbiter #(.NUM_REQ(3), .BUSY_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [23:0] data;
    logic        rdy;
    logic [2:0]  e_ready;
    logic        e_en;
    logic [7:0]  e_data;
    logic [2:0]  e_gid;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t tv [15];

  logic [8:0] qb [3][16];
  int qh [3];
  int qt [3];

  function automatic vec_t mk(logic [2:0] v, logic [23:0] d, logic r, logic [2:0] er,
                              logic ee, logic [7:0] ed, logic [2:0] eg, logic eb, logic ex);
    vec_t t;
    t.valid = v; t.data = d; t.rdy = r; t.e_ready = er; t.e_en = ee;
    t.e_data = ed; t.e_gid = eg; t.e_busy = eb; t.e_err = ex;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic qclear;
    for (int i = 0; i < 3; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
  endtask

  task automatic push(input int i, input logic l, input logic [7:0] d);
    qb[i][qt[i]] = {l, d};
    qt[i]++;
  endtask

  task automatic drive_reqs;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid[i] = qh[i] != qt[i];
      bus.req_data[i*8 +: 8] = qb[i][qh[i]][7:0];
      bus.req_last[i] = qb[i][qh[i]][8];
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    qclear;
    drive_reqs;
    bus.tx_rdy = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic grant_wait(output int who);
    who = -1;
    for (int c = 0; c < 30 && who < 0; c++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        chk("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
        for (int i = 0; i < 3; i++) if (bus.req_ready[i]) who = i;
        qh[who]++;
      end
      tick;
      drive_reqs;
    end
    if (who < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_wait: no req_ready within 30 cycles, expected a grant");
    end
  endtask

  task automatic finish_send(output logic [7:0] b);
    @(negedge clk);
    chk("launch_tx_en", bus.tx_en, 1);
    b = bus.tx_data;
    tick;
    bus.tx_rdy = 1'b0;
    @(negedge clk);
    chk("wait_busy_tx_en", bus.tx_en, 0);
    tick;
    tick;
    bus.tx_rdy = 1'b1;
    tick;
  endtask

  task automatic serve(output int who, output logic [7:0] b);
    grant_wait(who);
    b = 8'h00;
    if (who >= 0) finish_send(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int who;
    logic [7:0] b;
    int rr_who [6];
    logic [7:0] rr_byte [6];
    logic [7:0] bl_byte [5];
    rr_who = '{0, 1, 2, 0, 1, 2};
    rr_byte = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
`ifdef UART_TX_ARB_BURST_LOCK_EN
    bl_byte = '{8'h55, 8'h41, 8'h42, 8'h43, 8'h5A};
`else
    bl_byte = '{8'h55, 8'h41, 8'h5A, 8'h42, 8'h43};
`endif

    tv[0] = mk(3'b000, 24'h0, 1, 3'b000, 0, 8'h00, 3'd0, 0, 0);
    tv[1] = mk(3'b010, 24'h004100, 1, 3'b010, 0, 8'h00, 3'd0, 0, 0);
    tv[2] = mk(3'b000, 24'h0, 1, 3'b000, 1, 8'h41, 3'd1, 1, 0);
    for (int i = 3; i <= 12; i++) tv[i] = mk(3'b000, 24'h0, 0, 3'b000, 0, 8'h41, 3'd1, 1, 0);
    tv[13] = mk(3'b000, 24'h0, 1, 3'b000, 0, 8'h41, 3'd1, 1, 0);
    tv[14] = mk(3'b000, 24'h0, 1, 3'b000, 0, 8'h41, 3'd1, 0, 0);

    bus.req_last = '0;
    do_reset;
    for (int r = 0; r < 15; r++) begin
      bus.req_valid = tv[r].valid;
      bus.req_data = tv[r].data;
      bus.tx_rdy = tv[r].rdy;
      @(negedge clk);
      chk($sformatf("tv%0d_req_ready", r), bus.req_ready, tv[r].e_ready);
      chk($sformatf("tv%0d_tx_en", r), bus.tx_en, tv[r].e_en);
      chk($sformatf("tv%0d_tx_data", r), bus.tx_data, tv[r].e_data);
      chk($sformatf("tv%0d_grant_id", r), bus.grant_id, tv[r].e_gid);
      chk($sformatf("tv%0d_busy", r), bus.busy, tv[r].e_busy);
      chk($sformatf("tv%0d_err", r), bus.err, tv[r].e_err);
      tick;
    end

    do_reset;
    for (int i = 0; i < 3; i++) begin
      push(i, 1, 8'h10 * 8'(i + 1));
      push(i, 1, 8'h10 * 8'(i + 1) + 8'h01);
    end
    drive_reqs;
    for (int k = 0; k < 6; k++) begin
      serve(who, b);
      chk($sformatf("rr%0d_who", k), who, rr_who[k]);
      chk($sformatf("rr%0d_byte", k), b, rr_byte[k]);
    end

    do_reset;
    push(1, 1, 8'h55);
    drive_reqs;
    serve(who, b);
    chk("burst0_byte", b, bl_byte[0]);
    push(2, 0, 8'h41);
    push(2, 0, 8'h42);
    push(2, 1, 8'h43);
    push(0, 1, 8'h5A);
    drive_reqs;
    for (int k = 1; k < 5; k++) begin
      serve(who, b);
      chk($sformatf("burst%0d_byte", k), b, bl_byte[k]);
    end

    do_reset;
    push(0, 1, 8'h77);
    drive_reqs;
    grant_wait(who);
    chk("to_who", who, 0);
    @(negedge clk);
    chk("to_tx_en", bus.tx_en, 1);
    for (int k = 1; k <= 17; k++) begin
      tick;
      @(negedge clk);
      if (k <= 16) chk($sformatf("to_err_k%0d", k), bus.err, k == 16);
      if (k == 16) chk("to_busy_k16", bus.busy, 1);
      if (k == 17) chk("to_busy_k17", bus.busy, 0);
      if (k == 17) chk("to_err_sticky", bus.err, 1);
    end
    tick;
    push(1, 1, 8'h78);
    drive_reqs;
    serve(who, b);
    chk("to_next_who", who, 1);
    chk("to_next_byte", b, 8'h78);
    chk("to_err_held", bus.err, 1);

    do_reset;
    bus.tx_rdy = 1'b0;
    push(0, 1, 8'h33);
    drive_reqs;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stuck%0d_req_ready", k), bus.req_ready, 3'b000);
      chk($sformatf("stuck%0d_busy", k), bus.busy, 0);
      tick;
    end
    bus.tx_rdy = 1'b1;
    serve(who, b);
    chk("stuck_who", who, 0);
    chk("stuck_byte", b, 8'h33);

    do_reset;
    push(1, 1, 8'h42);
    drive_reqs;
    grant_wait(who);
    chk("mid_who", who, 1);
    tick;
    bus.tx_rdy = 1'b0;
    tick;
    @(negedge clk);
    chk("mid_busy_wait_done", bus.busy, 1);
    tick;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", bus.req_ready, 3'b000);
    tick;
    rst = 1'b0;
    bus.tx_rdy = 1'b1;
    @(negedge clk);
    chk("mid_post_req_ready", bus.req_ready, 3'b000);
    chk("mid_post_tx_en", bus.tx_en, 0);
    chk("mid_post_tx_data", bus.tx_data, 8'h00);
    chk("mid_post_grant_id", bus.grant_id, 3'd0);
    chk("mid_post_busy", bus.busy, 0);
    chk("mid_post_err", bus.err, 0);
    tick;
    push(0, 1, 8'h01);
    push(1, 1, 8'h02);
    drive_reqs;
    serve(who, b);
    chk("mid_after_who", who, 0);
    chk("mid_after_byte", b, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx_sol` byte transmitter between `NUM_REQ` byte sources, for example PC echo, password dump and gold-board relay, using round-robin arbitration. It owns the transmitter's `en`/`rdy` handshake: it pulses `en` once per byte, waits for `rdy` to fall and then rise, and only then grants the next byte. It sits between the command/relay logic in `top` and the transmitter instance. Optional burst locking keeps multi-byte messages, such as the 16-byte password dump, from being interleaved.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters (2..8).
- `BUSY_TIMEOUT`, default 16: maximum cycles after `tx_en` for `tx_rdy` to fall.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  **synchronous, active-high** reset.
- `req_valid`  in  NUM_REQ  requester i has a byte pending.
- `req_data`  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte of requester i ends its burst.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse; the byte of requester i is accepted this cycle.
- `tx_en`  out  1  enable pulse to the transmitter.
- `tx_data`  out  8  byte to the transmitter; registered.
- `tx_rdy`  in  1  transmitter ready.
- `grant_id`  out  3  index of the current or last grantee.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky flag for a busy-timeout.

## Operation
- **States:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - If `tx_rdy`=1 and any eligible `req_valid` is set, pick winner g by round-robin.
  - The search starts at `last+1` modulo `NUM_REQ`.
  - Assert `req_ready[g]`, register `tx_data`=byte g, `grant_id`=g, `last`=g, then go to LAUNCH.
- **LAUNCH:** `tx_en`=1 for exactly one cycle, then go to WAIT_BUSY. Clear the timeout counter.
- **WAIT_BUSY:**
  - On `tx_rdy`=0, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `BUSY_TIMEOUT`, set `err` and go to IDLE. No retry; the byte is dropped.
- **WAIT_DONE:** on `tx_rdy`=1, go to IDLE.
- **Requester contract:** a requester holds `req_valid`, `req_data` and `req_last` stable until it sees `req_ready`. Dropping `req_valid` before acceptance withdraws the request, with no side effects.
- **Eligibility:** all requesters are eligible unless a lock is active (see Configuration).
- **`tx_data`:** holds its value after send. It changes only on a grant.
- **Reset values:** `req_ready`=0, `tx_en`=0, `tx_data`=0, `grant_id`=0, `busy`=0, `err`=0, state IDLE, `last`=`NUM_REQ-1` (requester 0 wins first), lock cleared.
- **Reset mid-operation:** abandon the byte in flight and do not pulse `req_ready` again. `err` clears only on `rst`.

## Timing
- **Grant latency:** `req_valid` seen in IDLE (cycle 0) gives `req_ready` in cycle 0 (combinational from registered state) and `tx_en` in cycle 1.
- **Minimum inter-byte gap:** after `tx_rdy` rises in WAIT_DONE, IDLE is entered the next cycle. The next grant comes in that IDLE cycle, and `tx_en` one cycle later.
- **`tx_rdy` stuck low in IDLE:** no grant.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Losers keep waiting.
- **Fairness:** each active requester is served within `NUM_REQ` grants, without lock.
- **Timeout:** `err` rises in the cycle the counter equals `BUSY_TIMEOUT`. A `tx_rdy` fall in that same cycle takes precedence, so no error is raised.

## Configuration
- **Macro:** `UART_TX_ARB_BURST_LOCK_EN`.
- **Defined:**
  - Granting a byte with `req_last`=0 sets lock, owner=g.
  - While locked, only the owner is eligible in IDLE; others stall even if valid.
  - Granting the owner's byte with `req_last`=1 clears the lock.
  - A timeout also clears the lock.
- **Undefined:** `req_last` is ignored, there is no lock logic, and arbitration is per byte.

## Structure
- **Shared include `uart_defs.v`:** add the state encodings `TXARB_IDLE`/`LAUNCH`/`WAIT_BUSY`/`WAIT_DONE` (2-bit) and the default `BUSY_TIMEOUT`, next to `UART_FULL_ETU`.
- **Sub-module `rr_arb_pick`:** combinational. Inputs are the request vector, eligibility mask and `last`. Outputs are the one-hot grant and the index. It is natural to split out for reuse on the gold-board TX side.
- **Top level:** the FSM, timeout counter, lock registers and output registers.

## Test plan
- **Single request:** `req_valid[1]` with 0x41 and `tx_rdy`=1. Expect `req_ready[1]` in cycle 0, `tx_en`=1 and `tx_data`=0x41 in cycle 1. Hold `tx_rdy` low for 10 cycles, then high; `busy` falls 1 cycle after the rise.
- **Round-robin:** all three requesters hold valid. Grant order is 0,1,2,0,1,2; no requester is granted twice before the others.
- **Burst lock, macro on:** requester 2 sends "ABC" with `req_last` on 'C' while requester 0 is valid. Expect bytes A,B,C, then requester 0's byte. With the macro off, expect A, req0, B…
- **Timeout:** `tx_rdy` stays 1 after `tx_en`. `err`=1 exactly 16 cycles after `tx_en`, state returns to IDLE, and the next request is still served.
- **`tx_rdy` low in IDLE:** `req_valid[0]` set. No `req_ready` until `tx_rdy`=1.
- **Reset mid-send:** `rst` in WAIT_DONE. The next cycle has all outputs at reset values and `last` restored, and requester 0 wins over requester 1 afterwards.
